// File: rtl/dvi_timing_pkg.sv
// -----------------------------------------------------------------------------
// dvi_timing_pkg
// Shared types and constants for the DVI raster timing generator and the TMDS
// encoders it feeds.
//   timing_t         : one complete raster description (porches, sync widths)
//   TIMING_640X480   : 640x480@60 (25.175 MHz pixel clock)
//   TIMING_800X600   : 800x600@60 (40 MHz pixel clock)
//   ctrl_t           : control vector carried through the alignment delay line
//   TMDS_CTRL_*      : 10-bit control-period symbols, indexed by {C1,C0}
//   BAR_ROM          : colour-bar test pattern, entry 0 is the leftmost bar
// -----------------------------------------------------------------------------
package dvi_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } timing_t;

  localparam timing_t TIMING_640X480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33
  };

  localparam timing_t TIMING_800X600 = '{
    h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23
  };

  // Syncs are carried as raw "in sync window" flags; polarity is applied only
  // at the output so the all-zero vector is always the blank/inactive state.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic line_start;
    logic frame_start;
  } ctrl_t;

  localparam ctrl_t CTRL_BLANK = '0;

  typedef enum logic [1:0] {
    CTRL_SYM_00 = 2'b00,
    CTRL_SYM_01 = 2'b01,
    CTRL_SYM_10 = 2'b10,
    CTRL_SYM_11 = 2'b11
  } ctrl_sym_e;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Symbol sent during blanking for control bits {c1, c0}.
  function automatic logic [9:0] tmds_ctrl_symbol(input logic c1, input logic c0);
    ctrl_sym_e sel;
    sel = ctrl_sym_e'({c1, c0});
    case (sel)
      CTRL_SYM_00: tmds_ctrl_symbol = TMDS_CTRL_00;
      CTRL_SYM_01: tmds_ctrl_symbol = TMDS_CTRL_01;
      CTRL_SYM_10: tmds_ctrl_symbol = TMDS_CTRL_10;
      default:     tmds_ctrl_symbol = TMDS_CTRL_11;
    endcase
  endfunction

  // Packed so that index 0 is the leftmost bar (white).
  localparam logic [7:0][23:0] BAR_ROM = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/dvi_timing_gen_if.sv
// -----------------------------------------------------------------------------
// dvi_timing_gen_if
// Raster bundle between the timing generator (master) and its consumers
// (slave: pixel generator, TMDS encoders).
//   en_i          : run enable into the generator
//   x_o / y_o     : registered pixel counters
//   active_o      : undelayed DE aligned with x_o/y_o
//   de_o          : delayed DE for the encoders
//   hsync_o       : delayed hsync, polarity applied (encoder ch0 C0)
//   vsync_o       : delayed vsync, polarity applied (encoder ch0 C1)
//   line_start_o  : delayed pulse at h=0
//   frame_start_o : delayed pulse at h=0, v=0
//   rgb_o         : colour-bar pattern, present only with DVI_TIMING_PATTERN_EN
// -----------------------------------------------------------------------------
interface dvi_timing_gen_if #(
  parameter int W_H = 10,
  parameter int W_V = 10
);
  logic           en_i;
  logic [W_H-1:0] x_o;
  logic [W_V-1:0] y_o;
  logic           active_o;
  logic           de_o;
  logic           hsync_o;
  logic           vsync_o;
  logic           line_start_o;
  logic           frame_start_o;
`ifdef DVI_TIMING_PATTERN_EN
  logic [23:0]    rgb_o;

  modport master (
    input  en_i,
    output x_o, y_o, active_o, de_o, hsync_o, vsync_o,
    output line_start_o, frame_start_o, rgb_o
  );

  modport slave (
    output en_i,
    input  x_o, y_o, active_o, de_o, hsync_o, vsync_o,
    input  line_start_o, frame_start_o, rgb_o
  );
`else
  modport master (
    input  en_i,
    output x_o, y_o, active_o, de_o, hsync_o, vsync_o,
    output line_start_o, frame_start_o
  );

  modport slave (
    output en_i,
    input  x_o, y_o, active_o, de_o, hsync_o, vsync_o,
    input  line_start_o, frame_start_o
  );
`endif
endinterface

// File: rtl/dvi_delay_line.sv
// -----------------------------------------------------------------------------
// dvi_delay_line
// Fixed-depth shift register used to align control/pixel data with the
// downstream pipeline latency.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, loads RST_VAL into every stage
//   d_i     : input word
//   q_o     : d_i delayed by DEPTH clocks (DEPTH=0 is a plain wire)
// -----------------------------------------------------------------------------
module dvi_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH < 0) begin : g_bad_depth
    $fatal(1, "dvi_delay_line: DEPTH must be >= 0");
  end

  if (DEPTH == 0) begin : g_wire
    // Clock and reset are intentionally unused in the zero-depth case.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_chain
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_d;
      logic [WIDTH-1:0] stage_q;

      if (gi == 0) begin : g_head
        always_comb stage_d = d_i;
      end else begin : g_body
        always_comb stage_d = g_stage[gi-1].stage_q;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          stage_q <= RST_VAL;
        end else begin
          stage_q <= stage_d;
        end
      end
    end

    assign q_o = g_stage[DEPTH-1].stage_q;
  end

endmodule

// File: rtl/dvi_timing_gen.sv
// -----------------------------------------------------------------------------
// dvi_timing_gen
// Pixel-clock raster generator for a DVI transmitter. Produces the h/v
// counters, DE, HSYNC, VSYNC and line/frame strobes; the control outputs are
// delayed so they line up with a downstream pixel generator of known latency.
//
// Ports:
//   clk_i : pixel clock
//   rst_i : asynchronous active-high reset (outputs go blank immediately)
//   vid   : dvi_timing_gen_if.master (en_i in; counters, DE, syncs, strobes out)
//
// Build option: define DVI_TIMING_PATTERN_EN to add vid.rgb_o, an 8-bar colour
// pattern aligned with de_o. In that build the control path has at least one
// register stage so the registered pattern and DE stay aligned.
// -----------------------------------------------------------------------------
module dvi_timing_gen
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE = TIMING_640X480.h_active,
  parameter int H_FP     = TIMING_640X480.h_fp,
  parameter int H_SYNC   = TIMING_640X480.h_sync,
  parameter int H_BP     = TIMING_640X480.h_bp,
  parameter int V_ACTIVE = TIMING_640X480.v_active,
  parameter int V_FP     = TIMING_640X480.v_fp,
  parameter int V_SYNC   = TIMING_640X480.v_sync,
  parameter int V_BP     = TIMING_640X480.v_bp,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE_LAT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dvi_timing_gen_if.master  vid
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int W_H      = $clog2(H_TOTAL);
  localparam int W_V      = $clog2(V_TOTAL);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic HS_POL_B = (HS_POL != 0);
  localparam logic VS_POL_B = (VS_POL != 0);

`ifdef DVI_TIMING_PATTERN_EN
  // The pattern is a registered output, so the control path needs at least
  // one stage to stay aligned with it.
  localparam int CTRL_LAT = (PIPE_LAT == 0) ? 1 : PIPE_LAT;
`else
  localparam int CTRL_LAT = PIPE_LAT;
`endif

  // Elaboration-time parameter checks
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $fatal(1, "dvi_timing_gen: every timing parameter must be >= 1");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_bad_lat
    $fatal(1, "dvi_timing_gen: PIPE_LAT must be in 0..15");
  end

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [W_H-1:0] h_q, h_d;
  logic [W_V-1:0] v_q, v_d;

  // Disabled counters park at (0,0), so a re-enable always starts a fresh
  // frame with frame_start in the very first enabled cycle.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (vid.en_i) begin
      if (h_q == W_H'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == W_V'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Undelayed control decode
  // ---------------------------------------------------------------------------
  logic active;
  logic hs_raw;
  logic vs_raw;

  assign active = (h_q < W_H'(H_ACTIVE)) && (v_q < W_V'(V_ACTIVE));
  assign hs_raw = (h_q >= W_H'(HS_START)) && (h_q < W_H'(HS_END));
  // vs_raw only depends on v, so it switches at h=0 together with v.
  assign vs_raw = (v_q >= W_V'(VS_START)) && (v_q < W_V'(VS_END));

  ctrl_t ctrl_raw;
  ctrl_t ctrl_dly;

  // Blank while disabled; reset also blanks it so that with a zero-depth
  // chain the outputs still go inactive the moment reset asserts.
  always_comb begin
    ctrl_raw = CTRL_BLANK;
    if (vid.en_i && !rst_i) begin
      ctrl_raw.active      = active;
      ctrl_raw.hs          = hs_raw;
      ctrl_raw.vs          = vs_raw;
      ctrl_raw.line_start  = (h_q == '0);
      ctrl_raw.frame_start = (h_q == '0) && (v_q == '0);
    end
  end

  dvi_delay_line #(
    .WIDTH   ($bits(ctrl_t)),
    .DEPTH   (CTRL_LAT),
    .RST_VAL (CTRL_BLANK)
  ) u_ctrl_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ctrl_raw),
    .q_o   (ctrl_dly)
  );

  assign vid.x_o           = h_q;
  assign vid.y_o           = v_q;
  assign vid.active_o      = active;
  assign vid.de_o          = ctrl_dly.active;
  assign vid.hsync_o       = ctrl_dly.hs ^ ~HS_POL_B;
  assign vid.vsync_o       = ctrl_dly.vs ^ ~VS_POL_B;
  assign vid.line_start_o  = ctrl_dly.line_start;
  assign vid.frame_start_o = ctrl_dly.frame_start;

`ifdef DVI_TIMING_PATTERN_EN
  // ---------------------------------------------------------------------------
  // Colour-bar pattern: bar index is the number of constant boundaries
  // k*H_ACTIVE/8 (k=1..7) already reached by x, so no divider is needed.
  // ---------------------------------------------------------------------------
  logic [7:1]  past_bound;
  logic [2:0]  bar_idx;
  logic [23:0] rgb_raw;
  logic [23:0] rgb_dly;

  for (genvar gi = 1; gi < 8; gi++) begin : g_bound
    assign past_bound[gi] = (h_q >= W_H'(gi * H_ACTIVE / 8));
  end

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      bar_idx = bar_idx + {2'b00, past_bound[k]};
    end
  end

  assign rgb_raw = ctrl_raw.active ? BAR_ROM[bar_idx] : 24'h000000;

  dvi_delay_line #(
    .WIDTH   (24),
    .DEPTH   (CTRL_LAT),
    .RST_VAL (24'h000000)
  ) u_rgb_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rgb_raw),
    .q_o   (rgb_dly)
  );

  assign vid.rgb_o = rgb_dly;
`endif

endmodule

// File: tb/tb_dvi_timing_gen.sv
`timescale 1ns/1ps
module tb_dvi_timing_gen;

  // Small raster so several whole frames fit in a short run.
  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;   // 24
  localparam int VT = VA + VFP + VSW + VBP;   // 11
  localparam int W_H = $clog2(HT);
  localparam int W_V = $clog2(VT);

`ifdef DVI_TIMING_PATTERN_EN
  localparam int L0 = 1;
`else
  localparam int L0 = 0;
`endif
  localparam int L3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  dvi_timing_gen_if #(.W_H(W_H), .W_V(W_V)) vif0 ();
  dvi_timing_gen_if #(.W_H(W_H), .W_V(W_V)) vif3 ();
  assign vif0.en_i = en;
  assign vif3.en_i = en;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .PIPE_LAT(0)
  ) dut0 (.clk_i(clk), .rst_i(rst), .vid(vif0.master));

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1), .VS_POL(0), .PIPE_LAT(3)
  ) dut3 (.clk_i(clk), .rst_i(rst), .vid(vif3.master));

  typedef struct {
    bit act, hs, vs, ls, fs;
    logic [23:0] rgb;
  } raw_t;

  typedef struct {
    logic [31:0] x, y;
    logic act, de, hs, vs, ls, fs;
    logic [23:0] rgb;
  } obs_t;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int   checks   = 0;
  int   failures = 0;
  int   pos      = 0;   // linear pixel index = y*HT + x
  int   cycles   = 0;
  bit   done     = 0;
  raw_t hist[$];
  obs_t q0[$], q3[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a.x !== e.x || a.y !== e.y || a.act !== e.act || a.de !== e.de ||
        a.hs !== e.hs || a.vs !== e.vs || a.ls !== e.ls || a.fs !== e.fs ||
        a.rgb !== e.rgb) begin
      failures++;
      $display("FAIL %s t=%0t got x=%0d y=%0d act=%b de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h want x=%0d y=%0d act=%b de=%b hs=%b vs=%b ls=%b fs=%b rgb=%h",
               nm, $time, a.x, a.y, a.act, a.de, a.hs, a.vs, a.ls, a.fs, a.rgb,
               e.x, e.y, e.act, e.de, e.hs, e.vs, e.ls, e.fs, e.rgb);
    end
  endtask

  function automatic raw_t delayed(input int lat);
    raw_t blank;
    blank = '{act: 0, hs: 0, vs: 0, ls: 0, fs: 0, rgb: 24'h0};
    if (hist.size() > lat) return hist[hist.size() - 1 - lat];
    return blank;
  endfunction

  function automatic obs_t make_obs(input int x, input int y, input raw_t d,
                                    input bit hpol, input bit vpol);
    obs_t o;
    o.x   = x;
    o.y   = y;
    o.act = (x < HA) && (y < VA);
    o.de  = d.act;
    o.hs  = hpol ? d.hs : !d.hs;
    o.vs  = vpol ? d.vs : !d.vs;
    o.ls  = d.ls;
    o.fs  = d.fs;
`ifdef DVI_TIMING_PATTERN_EN
    o.rgb = d.rgb;
`else
    o.rgb = 24'h0;
`endif
    return o;
  endfunction

  // Issue one cycle of stimulus and queue what both DUTs must show this cycle.
  task automatic drive_cycle(input bit e);
    raw_t r;
    int x, y;
    en = e;
    x = pos % HT;
    y = pos / HT;
    r.act = e && (x < HA) && (y < VA);
    r.hs  = e && (x >= HA + HFP) && (x < HA + HFP + HSW);
    r.vs  = e && (y >= VA + VFP) && (y < VA + VFP + VSW);
    r.ls  = e && (x == 0);
    r.fs  = e && (x == 0) && (y == 0);
    r.rgb = r.act ? bars[(x * 8) / HA] : 24'h0;
    hist.push_back(r);
    if (hist.size() > 20) void'(hist.pop_front());
    q0.push_back(make_obs(x, y, delayed(L0), 1'b0, 1'b0));
    q3.push_back(make_obs(x, y, delayed(L3), 1'b1, 1'b0));
    pos = e ? (pos + 1) % (HT * VT) : 0;
    cycles++;
  endtask

  task automatic step(input bit e);
    @(posedge clk);
    #1;
    drive_cycle(e);
  endtask

  task automatic run(input bit e, input int n);
    for (int i = 0; i < n; i++) step(e);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pos = 0;
    hist.delete();
    drive_cycle(1'b1);
  endtask

  // Reset asserted between edges must blank the outputs with no clock edge.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_x0",  32'(vif0.x_o), 0);
    chk("rst_y0",  32'(vif0.y_o), 0);
    chk("rst_de0", 32'(vif0.de_o), 0);
    chk("rst_hs0", 32'(vif0.hsync_o), 1);
    chk("rst_vs0", 32'(vif0.vsync_o), 1);
    chk("rst_ls0", 32'(vif0.line_start_o), 0);
    chk("rst_fs0", 32'(vif0.frame_start_o), 0);
    chk("rst_x3",  32'(vif3.x_o), 0);
    chk("rst_de3", 32'(vif3.de_o), 0);
    chk("rst_hs3", 32'(vif3.hsync_o), 0);
    chk("rst_vs3", 32'(vif3.vsync_o), 1);
    chk("rst_fs3", 32'(vif3.frame_start_o), 0);
`ifdef DVI_TIMING_PATTERN_EN
    chk("rst_rgb0", 32'(vif0.rgb_o), 0);
    chk("rst_rgb3", 32'(vif3.rgb_o), 0);
`endif
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
    pos = 0;
    hist.delete();
    drive_cycle(1'b1);
  endtask

  // Monitor: every non-reset cycle both DUTs present one raster sample.
  initial begin
    obs_t a;
    forever begin
      @(negedge clk);
      if (!rst && !done) begin
        if (q0.size() == 0 || q3.size() == 0) begin
          chk("sb_underflow", 32'(q0.size() + q3.size()), 2);
        end else begin
          a.x = 32'(vif0.x_o); a.y = 32'(vif0.y_o); a.act = vif0.active_o;
          a.de = vif0.de_o; a.hs = vif0.hsync_o; a.vs = vif0.vsync_o;
          a.ls = vif0.line_start_o; a.fs = vif0.frame_start_o;
`ifdef DVI_TIMING_PATTERN_EN
          a.rgb = vif0.rgb_o;
`else
          a.rgb = 24'h0;
`endif
          cmp("dut0_cycle", a, q0.pop_front());
          a.x = 32'(vif3.x_o); a.y = 32'(vif3.y_o); a.act = vif3.active_o;
          a.de = vif3.de_o; a.hs = vif3.hsync_o; a.vs = vif3.vsync_o;
          a.ls = vif3.line_start_o; a.fs = vif3.frame_start_o;
`ifdef DVI_TIMING_PATTERN_EN
          a.rgb = vif3.rgb_o;
`else
          a.rgb = 24'h0;
`endif
          cmp("dut3_cycle", a, q3.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seg = 0;
    int len;
    int kind;
    int guard;
    int start;

    repeat (2) @(posedge clk);
    release_reset();
    $display("SEG %0d: two full frames from reset", seg++);
    run(1'b1, 2 * HT * VT + 5);

    // Drop enable mid-line, then re-enable: raster must restart at (0,0).
    guard = 0;
    while (pos != 3 * HT + 7 && guard < 2 * HT * VT) begin
      step(1'b1);
      guard++;
    end
    $display("SEG %0d: enable drop at line 3 pixel 7, hold 5", seg++);
    run(1'b0, 5);
    run(1'b1, 300);

    // Reset in the middle of active video.
    guard = 0;
    while (pos != 2 * HT + 5 && guard < 2 * HT * VT) begin
      step(1'b1);
      guard++;
    end
    $display("SEG %0d: async reset mid-active at line 2 pixel 5", seg++);
    do_reset(2);
    run(1'b1, 300);

    for (int i = 0; i < 40; i++) begin
      kind  = $urandom_range(0, 9);
      start = pos;
      if (kind < 7) begin
        len = $urandom_range(1, 400);
        $display("SEG %0d: enabled run len=%0d from pos=%0d", seg++, len, start);
        run(1'b1, len);
      end else if (kind < 9) begin
        len = $urandom_range(1, 10);
        $display("SEG %0d: disabled run len=%0d from pos=%0d", seg++, len, start);
        run(1'b0, len);
      end else begin
        len = $urandom_range(1, 4);
        $display("SEG %0d: async reset hold=%0d from pos=%0d", seg++, len, start);
        do_reset(len);
      end
    end

    @(negedge clk);
    #1;
    done = 1'b1;
    chk("sb_drain0", 32'(q0.size()), 0);
    chk("sb_drain3", 32'(q3.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
Video timing controller that sequences the three TMDS encoder channels. It generates the pixel-clock-domain raster: horizontal and vertical counters, DE, HSYNC, VSYNC, and frame and line strobes. A programmable delay aligns the control signals with the latency of the downstream pixel generator. Its outputs drive the encoders' DE, C0 and C1 inputs directly; channel 0 receives C0=hsync_o and C1=vsync_o.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
PIPE_LAT, 0, cycles of delay on de/sync/strobes relative to x_o/y_o (0..15)

Ports:
clk_i  in  1  pixel clock; one clock domain only
rst_i  in  1  asynchronous, active-high reset
en_i  in  1  run enable
x_o  out  W_H  horizontal counter; W_H = $clog2(H_TOTAL)
y_o  out  W_V  vertical counter; W_V = $clog2(V_TOTAL)
active_o  out  1  undelayed DE, aligned with x_o/y_o
de_o  out  1  delayed data enable, to encoder DE
hsync_o  out  1  delayed hsync with polarity applied
vsync_o  out  1  delayed vsync with polarity applied
line_start_o  out  1  delayed one-cycle pulse at h=0
frame_start_o  out  1  delayed one-cycle pulse at h=0, v=0

Behaviour:
- H_TOTAL = sum of the four H_* parameters (800 by default). V_TOTAL = sum of the four V_* parameters (525 by default).
- Horizontal order: active, front porch, sync, back porch.
  - h counts 0..H_TOTAL-1 and wraps to 0.
  - v increments when h wraps.
  - v wraps from V_TOTAL-1 to 0.
- active = (h < H_ACTIVE) and (v < V_ACTIVE).
- hs_raw = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vs_raw asserts for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, switching at h=0.
- x_o/y_o are the registered counters. active_o is combinational from those counters.
- The {active, hs_raw, vs_raw, line_start, frame_start} vector passes through a PIPE_LAT-stage register chain.
  - PIPE_LAT=0 means a direct connection.
  - Polarity is applied after the chain: hsync_o = hs_raw ^ ~HS_POL, and likewise for vsync_o.
- en_i low, sampled each edge:
  - Counters load 0 and hold.
  - The chain input is forced to the blank vector (active=0, syncs inactive, strobes 0).
  - The pipeline keeps shifting, so it drains in PIPE_LAT cycles.
- en_i rising: the counters sit at (0,0), so frame_start fires in the first enabled cycle. The raster starts at pixel (0,0).
- Reset is asynchronous and immediate, with no clock edge needed:
  - h, v and all chain stages clear.
  - de_o, line_start_o and frame_start_o go to 0.
  - hsync_o = ~HS_POL and vsync_o = ~VS_POL (the inactive levels).
  - x_o and y_o go to 0.
- Elaboration checks: every timing parameter must be >= 1, and PIPE_LAT must be <= 15. Violations are $fatal.

Optional Feature:
DVI_TIMING_PATTERN_EN:
- Defined: adds output rgb_o[23:0], a registered 8-bar colour pattern.
  - Bar index = number of bar boundaries k*H_ACTIVE/8 (k=1..7) that are <= x. Boundaries are compared as constants; no divider.
  - Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - rgb_o is 0 when not active.
  - rgb_o is delayed to align exactly with de_o, i.e. max(PIPE_LAT,1) stages. When PIPE_LAT=0, control signals get one extra stage instead.
  - Reset value of rgb_o is 0.
- Undefined: port rgb_o and its logic are absent, and latency is exactly PIPE_LAT.

Decomposition:
- Package dvi_timing_pkg holds:
  - a timing struct type {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp}
  - localparam 640x480@60 and 800x600@60 struct constants
  - TMDS control symbol constants shared with the encoder
  - a bar colour ROM constant array
- Sub-module dvi_delay_line: parameterised width/depth shift register with async reset and a per-bit reset value.

Test Plan:
1. Default parameters, PIPE_LAT=0, en_i=1 after reset:
   - de_o high for h 0..639 of lines 0..479.
   - hsync_o low exactly for h 656..751.
   - Line period is 800 cycles.
2. Full frame:
   - vsync_o low for exactly lines 490..491 (1600 cycles).
   - frame_start_o pulses every 420000 cycles.
   - line_start_o pulses 525 times per frame.
3. PIPE_LAT=3:
   - de_o rises 3 cycles after x_o=0 with active_o=1.
   - hsync_o falls 3 cycles after x_o=656.
4. en_i dropped at h=300 of line 10:
   - x_o/y_o read 0 on the next cycle.
   - de_o goes low PIPE_LAT cycles later.
   - After re-enable, the first cycle gives frame_start_o (delayed by PIPE_LAT).
5. rst_i asserted mid-active between clock edges:
   - de_o=0 and hsync_o=vsync_o=1 immediately.
   - After release, the raster restarts at (0,0).
6. DVI_TIMING_PATTERN_EN defined:
   - rgb_o = FFFFFF while x=0..79, FFFF00 at x=80, 000000 at x=560..639.
   - rgb_o = 0 during blanking, and aligned with de_o.
